// File: rtl/mem_responder_if.sv
// Load/store request and response channels between the CPU memory stage and the responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised data-memory responder: one outstanding load/store, fixed access latency,
// byte-masked writes and an error response for misaligned or out-of-range addresses.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);
  localparam logic [29:0] DepthW  = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_req_ready, w_req_ready_next;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_acc_write;
  logic [31:0]     w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [3:0]      w_acc_wmask;
  logic            w_acc_err;
  logic [IdxW-1:0] w_acc_idx;

  assign w_accept = bus.req_valid && r_req_ready;

  // With LATENCY=1 the access happens on the accept edge, before the latch holds the request.
  assign w_acc_write = (r_state == StIdle) ? bus.req_write : r_write;
  assign w_acc_addr  = (r_state == StIdle) ? bus.req_addr  : r_addr;
  assign w_acc_wdata = (r_state == StIdle) ? bus.req_wdata : r_wdata;
  assign w_acc_wmask = (r_state == StIdle) ? bus.req_wmask : r_wmask;
  assign w_acc_idx   = w_acc_addr[IdxW+1:2];
  assign w_acc_err   = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= DepthW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= w_req_ready_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = StResp;
          end else begin
            w_state_next = StWait;
            w_cnt_next   = CntLoad;
          end
        end
      end
      StWait: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = StResp;
      end
      StResp: begin
        if (bus.resp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_req_ready_next = (w_state_next == StIdle);
    bus.req_ready    = r_req_ready;
    bus.resp_valid   = (r_state == StResp);
    bus.resp_rdata   = r_rdata;
    bus.resp_err     = r_err;
  end

  assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wmask <= 4'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wmask <= bus.req_wmask;
      end
      if (w_enter_resp) begin
        r_err   <= w_acc_err;
        r_rdata <= (w_acc_err || w_acc_write) ? 32'h0 : r_mem[w_acc_idx];
      end
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_acc_write && !w_acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_wmask[i]) r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
      end
    end
  end
endmodule
